// File: rtl/id_hazard_unit_pkg.sv
// Shared constants and types for the decode-stage hazard/bypass unit.
package id_hazard_unit_pkg;

  // Pipeline stall bus layout: bit StallIdIdx freezes the ID register.
  localparam int unsigned StallBusW  = 6;
  localparam int unsigned StallIdIdx = 1;
  localparam logic        Stop       = 1'b1;
  localparam logic        NoStop     = 1'b0;

  // stall_cause bit positions.
  localparam int unsigned CauseRsBit = 0;
  localparam int unsigned CauseRtBit = 1;
  localparam int unsigned CauseMdBit = 2;
  localparam int unsigned CauseW     = 3;

  // Architectural zero register; never forwarded.
  localparam int unsigned RegZero = 0;

  typedef enum logic {
    StEmpty,
    StFull
  } hold_state_e;

endpackage

// File: rtl/id_fwd_select.sv
// Priority bypass select for one source operand: lowest matching index wins,
// and a not-ready winner raises a hazard instead of falling through to older data.
module id_fwd_select
  import id_hazard_unit_pkg::*;
#(
  parameter int unsigned NumFwd = 2,
  parameter int unsigned Dw     = 32,
  parameter int unsigned Aw     = 5
) (
  input  logic [Aw-1:0]        addr_i,
  input  logic                 used_i,
  input  logic [Dw-1:0]        rf_rdata_i,
  input  logic [NumFwd-1:0]    fwd_we_i,
  input  logic [NumFwd*Aw-1:0] fwd_waddr_i,
  input  logic [NumFwd*Dw-1:0] fwd_wdata_i,
  input  logic [NumFwd-1:0]    fwd_ready_i,
  output logic [Dw-1:0]        data_o,
  output logic                 hazard_o
);

  logic          hit;
  logic          hit_ready;
  logic [Dw-1:0] hit_data;

  // Scan oldest to youngest so the youngest match overwrites the selection.
  always_comb begin
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = rf_rdata_i;
    for (int i = NumFwd - 1; i >= 0; i--) begin
      if (fwd_we_i[i] && (fwd_waddr_i[i*Aw +: Aw] == addr_i) && (addr_i != Aw'(RegZero))) begin
        hit       = 1'b1;
        hit_ready = fwd_ready_i[i];
        hit_data  = fwd_wdata_i[i*Dw +: Dw];
      end
    end
  end

  // Drive operand and hazard from the winning source.
  always_comb begin
    data_o   = (hit && hit_ready) ? hit_data : rf_rdata_i;
    hazard_o = used_i & hit & ~hit_ready;
  end

endmodule

// File: rtl/id_hazard_unit.sv
// Decode-stage operand bypass, interlock generation, mult/div busy tracking
// and instruction hold buffer for ID stalls.
module id_hazard_unit
  import id_hazard_unit_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned MD_LAT  = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_id,
  input  logic [DW-1:0]         inst_in,
  output logic [DW-1:0]         inst_out,
  input  logic [AW-1:0]         rs_addr,
  input  logic [AW-1:0]         rt_addr,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic [DW-1:0]         rf_rdata1,
  input  logic [DW-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [NUM_FWD*AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*DW-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]    fwd_ready,
  input  logic                  md_start,
  input  logic                  md_read,
  output logic [DW-1:0]         rs_data,
  output logic [DW-1:0]         rt_data,
  output logic                  stallreq,
  output logic [CauseW-1:0]     stall_cause
);

  localparam int unsigned CntW = $clog2(MD_LAT + 1);

  logic            rs_hazard;
  logic            rt_hazard;
  logic            md_busy;
  logic [CntW-1:0] md_cnt_d, md_cnt_q;
  hold_state_e     hold_state_d, hold_state_q;
  logic [DW-1:0]   hold_buf_d, hold_buf_q;

  id_fwd_select #(
    .NumFwd (NUM_FWD),
    .Dw     (DW),
    .Aw     (AW)
  ) u_fwd_rs (
    .addr_i      (rs_addr),
    .used_i      (rs_used),
    .rf_rdata_i  (rf_rdata1),
    .fwd_we_i    (fwd_we),
    .fwd_waddr_i (fwd_waddr),
    .fwd_wdata_i (fwd_wdata),
    .fwd_ready_i (fwd_ready),
    .data_o      (rs_data),
    .hazard_o    (rs_hazard)
  );

  id_fwd_select #(
    .NumFwd (NUM_FWD),
    .Dw     (DW),
    .Aw     (AW)
  ) u_fwd_rt (
    .addr_i      (rt_addr),
    .used_i      (rt_used),
    .rf_rdata_i  (rf_rdata2),
    .fwd_we_i    (fwd_we),
    .fwd_waddr_i (fwd_waddr),
    .fwd_wdata_i (fwd_wdata),
    .fwd_ready_i (fwd_ready),
    .data_o      (rt_data),
    .hazard_o    (rt_hazard)
  );

  // Combine hazard sources into the stall request and its cause vector.
  always_comb begin
    md_busy                 = (md_cnt_q != '0) & (md_start | md_read);
    stall_cause             = '0;
    stall_cause[CauseRsBit] = rs_hazard;
    stall_cause[CauseRtBit] = rt_hazard;
    stall_cause[CauseMdBit] = md_busy;
    stallreq                = rs_hazard | rt_hazard | md_busy;
  end

  // Mult/div occupancy counter: flush wins over a new issue.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (flush) begin
      md_cnt_d = '0;
    end else if (md_start && !stallreq && (stall_id == NoStop)) begin
      md_cnt_d = CntW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // Hold FSM: capture the SRAM word once on stall entry, replay it until release.
  always_comb begin
    hold_state_d = hold_state_q;
    hold_buf_d   = hold_buf_q;
    inst_out     = inst_in;
    unique case (hold_state_q)
      StEmpty: begin
        if ((stall_id == Stop) && !flush) begin
          hold_buf_d   = inst_in;
          hold_state_d = StFull;
        end
      end
      StFull: begin
        // Buffer still feeds decode in the release cycle.
        inst_out = hold_buf_q;
        if ((stall_id == NoStop) || flush) begin
          hold_state_d = StEmpty;
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q     <= '0;
      hold_state_q <= StEmpty;
      hold_buf_q   <= '0;
    end else begin
      md_cnt_q     <= md_cnt_d;
      hold_state_q <= hold_state_d;
      hold_buf_q   <= hold_buf_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Self-checking bench for id_hazard_unit: directed scenarios then random
// traffic, all compared against a behavioural model.
module tb_id_hazard_unit;
  import id_hazard_unit_pkg::*;

  localparam int unsigned NF  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 stall_id;
  logic [StallBusW-1:0] stall_bus;
  logic [DW-1:0]        inst_in, inst_out;
  logic [AW-1:0]        rs_addr, rt_addr;
  logic                 rs_used, rt_used;
  logic [DW-1:0]        rf_rdata1, rf_rdata2;
  logic [NF-1:0]        fwd_we, fwd_ready;
  logic [NF*AW-1:0]     fwd_waddr;
  logic [NF*DW-1:0]     fwd_wdata;
  logic                 md_start, md_read;
  logic [DW-1:0]        rs_data, rt_data;
  logic                 stallreq;
  logic [CauseW-1:0]    stall_cause;

  // Per-source stimulus, packed onto the DUT buses below.
  bit            we_a  [NF];
  bit            rdy_a [NF];
  logic [AW-1:0] wa_a  [NF];
  logic [DW-1:0] wd_a  [NF];

  // Model state.
  int            cyc;
  int            md_end;     // last cycle the mult/div unit is occupied
  bit            hold_full;
  logic [DW-1:0] hold_word;
  bit            exp_stall;

  int n_vec;
  int n_err;

  assign stall_id = stall_bus[StallIdIdx];

  always_comb begin
    fwd_we    = '0;
    fwd_ready = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
    for (int i = 0; i < NF; i++) begin
      fwd_we[i]              = we_a[i];
      fwd_ready[i]           = rdy_a[i];
      fwd_waddr[i*AW +: AW]  = wa_a[i];
      fwd_wdata[i*DW +: DW]  = wd_a[i];
    end
  end

  id_hazard_unit #(
    .NUM_FWD (NF),
    .DW      (DW),
    .AW      (AW),
    .MD_LAT  (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall_id    (stall_id),
    .inst_in     (inst_in),
    .inst_out    (inst_out),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_used     (rs_used),
    .rt_used     (rt_used),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .fwd_we      (fwd_we),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .fwd_ready   (fwd_ready),
    .md_start    (md_start),
    .md_read     (md_read),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .stallreq    (stallreq),
    .stall_cause (stall_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_stall(input bit s);
    stall_bus             = '0;
    stall_bus[StallIdIdx] = s;
  endtask

  task automatic clear_inputs();
    rst       = 1'b0;
    flush     = 1'b0;
    set_stall(1'b0);
    inst_in   = '0;
    rs_addr   = '0;
    rt_addr   = '0;
    rs_used   = 1'b0;
    rt_used   = 1'b0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    md_start  = 1'b0;
    md_read   = 1'b0;
    for (int i = 0; i < NF; i++) begin
      we_a[i]  = 1'b0;
      rdy_a[i] = 1'b0;
      wa_a[i]  = '0;
      wd_a[i]  = '0;
    end
  endtask

  // Youngest source writing the register decides; r0 never forwards.
  task automatic ref_operand(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                             output bit hit, output bit rdy, output logic [DW-1:0] d);
    hit = 1'b0;
    rdy = 1'b0;
    d   = rf;
    if (a != 0) begin
      for (int i = 0; i < NF; i++) begin
        if (!hit && we_a[i] && wa_a[i] == a) begin
          hit = 1'b1;
          rdy = rdy_a[i];
          if (rdy) d = wd_a[i];
        end
      end
    end
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic settle_check();
    bit            hs, rs_rdy, ht, rt_rdy, rs_h, rt_h, md_b;
    logic [DW-1:0] ds, dt;
    #3;
    ref_operand(rs_addr, rf_rdata1, hs, rs_rdy, ds);
    ref_operand(rt_addr, rt_addr == rt_addr ? rf_rdata2 : rf_rdata2, ht, rt_rdy, dt);
    rs_h      = rs_used && hs && !rs_rdy;
    rt_h      = rt_used && ht && !rt_rdy;
    md_b      = (cyc <= md_end) && (md_start || md_read);
    exp_stall = rs_h || rt_h || md_b;
    check_val("stallreq", 32'(stallreq), 32'(exp_stall));
    check_val("stall_cause", 32'(stall_cause), 32'({md_b, rt_h, rs_h}));
    check_val("inst_out", inst_out, hold_full ? hold_word : inst_in);
    if (!hs || rs_rdy) check_val("rs_data", rs_data, ds);
    if (!ht || rt_rdy) check_val("rt_data", rt_data, dt);
  endtask

  // Advance the model by one clock, then move past the edge.
  task automatic tick();
    bit accept;
    accept = md_start && !exp_stall && !stall_id;
    if (rst) begin
      md_end    = cyc;
      hold_full = 1'b0;
      hold_word = '0;
    end else begin
      if (flush)       md_end = cyc;
      else if (accept) md_end = cyc + LAT;
      if (!hold_full) begin
        if (stall_id && !flush) begin
          hold_full = 1'b1;
          hold_word = inst_in;
        end
      end else if (!stall_id || flush) begin
        hold_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    md_end    = -1;
    hold_full = 1'b0;
    hold_word = '0;
    exp_stall = 1'b0;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // First reset edge leaves state defined; no checks before it.
    tick();

    // Reset state.
    rst     = 1'b1;
    inst_in = 32'h1357_9bdf;
    settle_check();
    tick();
    rst = 1'b0;
    inst_in = 32'h2468_ace0;
    md_read = 1'b1;
    settle_check();
    check_val("reset_stallreq", 32'(stallreq), 32'd0);
    check_val("reset_inst_out", inst_out, 32'h2468_ace0);
    tick();

    // Priority bypass: youngest wins, older used once youngest drops out.
    clear_inputs();
    we_a[0] = 1; wa_a[0] = 5'd8; wd_a[0] = 32'h11; rdy_a[0] = 1;
    we_a[1] = 1; wa_a[1] = 5'd8; wd_a[1] = 32'h22; rdy_a[1] = 1;
    rs_addr = 5'd8; rs_used = 1'b1; rf_rdata1 = 32'hdead_beef;
    settle_check();
    check_val("prio_ex", rs_data, 32'h11);
    check_val("prio_stall", 32'(stallreq), 32'd0);
    tick();
    we_a[0] = 0;
    settle_check();
    check_val("prio_mem", rs_data, 32'h22);
    tick();

    // Load-use: younger not-ready match is not masked by older ready one.
    clear_inputs();
    we_a[0] = 1; wa_a[0] = 5'd9; rdy_a[0] = 0;
    we_a[1] = 1; wa_a[1] = 5'd9; wd_a[1] = 32'h33; rdy_a[1] = 1;
    rt_addr = 5'd9; rt_used = 1'b1;
    settle_check();
    check_val("lu_stall", 32'(stallreq), 32'd1);
    check_val("lu_cause", 32'(stall_cause), 32'b010);
    tick();
    we_a[0] = 0; wd_a[1] = 32'h5a;
    settle_check();
    check_val("lu_data", rt_data, 32'h5a);
    check_val("lu_release", 32'(stallreq), 32'd0);
    tick();

    // Register zero and unused operand.
    clear_inputs();
    we_a[0] = 1; wa_a[0] = 5'd0; wd_a[0] = 32'hffff_ffff; rdy_a[0] = 1;
    rs_addr = 5'd0; rs_used = 1'b1; rf_rdata1 = 32'h0;
    settle_check();
    check_val("r0_data", rs_data, 32'h0);
    tick();
    clear_inputs();
    we_a[0] = 1; wa_a[0] = 5'd7; rdy_a[0] = 0;
    rt_addr = 5'd7; rt_used = 1'b0;
    settle_check();
    check_val("unused_stall", 32'(stallreq), 32'd0);
    tick();

    // Mult/div busy window.
    clear_inputs();
    md_start = 1'b1;
    settle_check();
    check_val("md_issue", 32'(stallreq), 32'd0);
    tick();
    md_start = 1'b0;
    md_read  = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      settle_check();
      check_val("md_busy", 32'(stall_cause), 32'b100);
      tick();
    end
    settle_check();
    check_val("md_done", 32'(stallreq), 32'd0);
    tick();

    // Flush cuts the busy window short.
    clear_inputs();
    md_start = 1'b1;
    settle_check();
    tick();
    md_start = 1'b0;
    md_read  = 1'b1;
    settle_check();
    check_val("mdf_c1", 32'(stallreq), 32'd1);
    tick();
    flush = 1'b1;
    settle_check();
    check_val("mdf_c2", 32'(stallreq), 32'd1);
    tick();
    flush = 1'b0;
    settle_check();
    check_val("mdf_c3", 32'(stallreq), 32'd0);
    tick();

    // Instruction hold across a 3-cycle stall.
    clear_inputs();
    inst_in = 32'haaaa_0000;
    set_stall(1'b1);
    settle_check();
    check_val("hold_c0", inst_out, 32'haaaa_0000);
    tick();
    inst_in = 32'hbbbb_0000;
    for (int c = 0; c < 2; c++) begin
      settle_check();
      check_val("hold_stall", inst_out, 32'haaaa_0000);
      tick();
    end
    set_stall(1'b0);
    settle_check();
    check_val("hold_release", inst_out, 32'haaaa_0000);
    tick();
    settle_check();
    check_val("hold_follow", inst_out, 32'hbbbb_0000);
    tick();

    // Reset in the middle of a busy window with the hold buffer full.
    clear_inputs();
    md_start = 1'b1;
    settle_check();
    tick();
    md_start = 1'b0;
    inst_in  = 32'h1234_5678;
    set_stall(1'b1);
    settle_check();
    tick();
    rst = 1'b1;
    settle_check();
    tick();
    rst = 1'b0;
    set_stall(1'b0);
    md_read = 1'b1;
    inst_in = 32'hcafe_f00d;
    settle_check();
    check_val("rst_mid_stall", 32'(stallreq), 32'd0);
    check_val("rst_mid_inst", inst_out, 32'hcafe_f00d);
    tick();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      set_stall($urandom_range(0, 2) == 0);
      inst_in   = $urandom;
      rs_addr   = AW'($urandom_range(0, 3));
      rt_addr   = AW'($urandom_range(0, 3));
      rs_used   = $urandom_range(0, 1) == 1;
      rt_used   = $urandom_range(0, 1) == 1;
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      md_start  = ($urandom_range(0, 7) == 0);
      md_read   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NF; i++) begin
        we_a[i]  = $urandom_range(0, 1) == 1;
        rdy_a[i] = $urandom_range(0, 3) != 0;
        wa_a[i]  = AW'($urandom_range(0, 3));
        wd_a[i]  = $urandom;
      end
      settle_check();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
